// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizer, frame FSM with timeout, FWFT byte FIFO.
// Optional macro PS2_GLITCH_FILTER_EN adds a run-length glitch filter on ps2_clk.
module ps2_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       filtered;
  logic       prev_filt;
  logic       fall;
  logic       data_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int RW = $clog2(FILTER_LEN + 1);
  logic [RW-1:0] run_cnt;
  logic          filt;

  // The level only flips after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= 1'b0;
      run_cnt <= '0;
    end else if (clk_sync[1] == filt) begin
      run_cnt <= '0;
    end else if (run_cnt == RW'(FILTER_LEN - 1)) begin
      filt    <= clk_sync[1];
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
  assign filtered = filt;
`else
  assign filtered = clk_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_filt <= 1'b0;
    else        prev_filt <= filtered;
  end

  assign fall     = prev_filt & ~filtered;
  assign data_bit = data_sync[1];

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          push_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {data_bit, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            par_ok <= ^{shreg, data_bit};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_bit)   frame_err  <= 1'b1;
            else if (!par_ok) parity_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // Stalled frame: abandon it and resynchronise on the next start bit.
        state     <= IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end
    end
  end

  assign push_req = fall && (state == STOP) && data_bit && par_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign rx_valid   = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = rx_valid && rx_ready;
  // A full FIFO still accepts a byte when the head is leaving this cycle.
  assign wr_en      = push_req && (!full || pop);
  assign rx_data    = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: drives PS/2 frames, checks bytes, counts and error pulses.
module tb_ps2_rx;
  localparam int CLK_HZ     = 1_000_000;
  localparam int TIMEOUT_US = 200;
  localparam int DEPTH      = 8;
  localparam int FLEN       = 8;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       parity_err, frame_err, overflow;

  int vectors = 0;
  int miscompares = 0;
  int perr_n = 0, ferr_n = 0, ovf_n = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  ps2_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) perr_n++;
    if (frame_err)  ferr_n++;
    if (overflow)   ovf_n++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits < 11 sends a truncated frame; glitch_at injects a short low pulse in that bit's high phase.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cycles(HALF / 2);
        ps2_clk = 1'b0;
        wait_cycles(4);
        ps2_clk = 1'b1;
      end
      wait_cycles(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b0, 11, -1);
    if (model_count < DEPTH) begin
      exp_q.push_back(d);
      model_count++;
    end
  endtask

  task automatic drain(input string name);
    logic [7:0] exp_b;
    int waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (!rx_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      exp_b = exp_q.pop_front();
      vectors++;
      if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
        miscompares++;
        $display("FAIL %s pop: valid=%b data=%h, required valid=1 data=%h", name, rx_valid, rx_data, exp_b);
      end else begin
        $display("%s pop data=%h", name, rx_data);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      if (model_count > 0) model_count--;
    end
    vectors++;
    if (rx_valid !== 1'b0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL %s empty: valid=%b count=%0d, required valid=0 count=0", name, rx_valid, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(5);
    vectors++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 4'd0 ||
        parity_err !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%b data=%h count=%0d perr=%b ferr=%b ovf=%b, required all 0",
               rx_valid, rx_data, fifo_count, parity_err, frame_err, overflow);
    end else $display("reset outputs idle");
    rst_n = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_single();
    int p0, f0, o0;
    p0 = perr_n; f0 = ferr_n; o0 = ovf_n;
    send_good(8'h1C);
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h1C || fifo_count !== 4'd1) begin
      miscompares++;
      $display("FAIL single: valid=%b data=%h count=%0d, required 1 1c 1", rx_valid, rx_data, fifo_count);
    end else $display("single frame 1c held at head");
    vectors++;
    if (perr_n != p0 || ferr_n != f0 || ovf_n != o0) begin
      miscompares++;
      $display("FAIL single_err: pulses p=%0d f=%0d o=%0d, required 0 0 0", perr_n - p0, ferr_n - f0, ovf_n - o0);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    send_good(8'hF0);
    send_good(8'h1C);
    vectors++;
    if (fifo_count !== 4'(model_count)) begin
      miscompares++;
      $display("FAIL b2b_count: count=%0d, required %0d", fifo_count, model_count);
    end else $display("b2b count=%0d", fifo_count);
    drain("b2b");
  endtask

  task automatic test_parity();
    int p0;
    p0 = perr_n;
    send_frame(8'h1C, 1'b1, 11, -1);
    vectors++;
    if (perr_n - p0 != 1 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL parity: pulses=%0d count=%0d, required 1 0", perr_n - p0, fifo_count);
    end else $display("parity error frame dropped");
    send_good(8'h2A);
    drain("parity_next");
  endtask

  task automatic test_timeout();
    int f0;
    f0 = ferr_n;
    send_frame(8'h0F, 1'b0, 4, -1);
    wait_cycles(100);
    vectors++;
    if (ferr_n != f0) begin
      miscompares++;
      $display("FAIL timeout_early: pulses=%0d, required 0", ferr_n - f0);
    end
    wait_cycles(200);
    vectors++;
    if (ferr_n - f0 != 1 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL timeout: pulses=%0d count=%0d, required 1 0", ferr_n - f0, fifo_count);
    end else $display("timeout frame_err seen");
    send_good(8'h55);
    drain("timeout_next");
  endtask

  task automatic test_overflow();
    int o0;
    o0 = ovf_n;
    for (int v = 1; v <= 9; v++) send_good(8'(v));
    vectors++;
    if (ovf_n - o0 != 1 || fifo_count !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow: pulses=%0d count=%0d, required 1 8", ovf_n - o0, fifo_count);
    end else $display("overflow on 9th frame, count=8");
    drain("overflow");
  endtask

  task automatic test_reset_mid();
    send_good(8'h77);
    send_frame(8'hAA, 1'b0, 6, -1);
    rst_n = 1'b0;
    wait_cycles(3);
    vectors++;
    if (rx_valid !== 1'b0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b count=%0d, required 0 0", rx_valid, fifo_count);
    end else $display("mid-frame reset cleared fifo");
    exp_q.delete();
    model_count = 0;
    rst_n = 1'b1;
    wait_cycles(20);
    send_good(8'h33);
    drain("reset_mid");
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic test_glitch();
    int f0, p0;
    f0 = ferr_n; p0 = perr_n;
    send_frame(8'h5A, 1'b0, 11, 4);
    exp_q.push_back(8'h5A);
    model_count++;
    vectors++;
    if (ferr_n != f0 || perr_n != p0 || fifo_count !== 4'd1) begin
      miscompares++;
      $display("FAIL glitch: ferr=%0d perr=%0d count=%0d, required 0 0 1", ferr_n - f0, perr_n - p0, fifo_count);
    end else $display("glitch ignored");
    drain("glitch");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_overflow();
    test_reset_mid();
`ifdef PS2_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
